// File: rtl/network_mac_pkg.sv
// Shared constants and fixed-point helpers for the network MAC pipeline.
// Helpers work on a 64-bit signed carrier so any lane width up to 63 bits fits.
package network_mac_pkg;

    localparam int CALC_W       = 64;
    localparam int DEF_LANES    = 4;
    localparam int DEF_A_W      = 16;
    localparam int DEF_B_W      = 13;
    localparam int DEF_NUM_STAGE = 2;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_SHIFT    = 12;
    localparam int DEF_OUT_W    = 16;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    function automatic logic sat_flag(input logic signed [CALC_W-1:0] v, input int w);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_to_width(input logic signed [CALC_W-1:0] v,
                                                              input int w);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    // Round half-up, then arithmetic shift out the fractional bits.
    function automatic logic signed [CALC_W-1:0] round_shift(input logic signed [CALC_W-1:0] v,
                                                             input int sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/network_mac_pipe_if.sv
// Stream interface of the MAC pipe: input beat channel and result channel.
interface network_mac_pipe_if
    import network_mac_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*A_W-1:0]   in_a;
    logic [B_W-1:0]         in_b;
    logic                   in_acc;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/network_mac_lane.sv
// One lane: pipelined signed x unsigned multiply, saturating accumulator,
// and registered round/saturate output. Control comes from the top.
module network_mac_lane
    import network_mac_pkg::*;
#(
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int NUM_STAGE = DEF_NUM_STAGE,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             adv_i,
    input  logic             take_i,
    input  logic             add_i,
    input  logic             close_i,
    input  logic             load_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);
    localparam int P_W = prod_width(A_W, B_W);

    logic signed [P_W-1:0]    a_ext_s;
    logic signed [P_W-1:0]    b_ext_s;
    logic signed [P_W-1:0]    prod_s;
    logic signed [P_W-1:0]    p_q [NUM_STAGE];
    logic signed [CALC_W-1:0] p_ext_s;
    logic signed [CALC_W-1:0] acc_ext_s;
    logic signed [CALC_W-1:0] sum_s;
    logic signed [CALC_W-1:0] rnd_s;
    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         acc_d;
    logic                     grp_sat_q;
    logic                     grp_sat_d;
    logic                     emit_sat_q;
    logic                     emit_sat_d;
    logic                     sticky_s;
    logic [OUT_W-1:0]         data_q;
    logic                     sat_q;

    // Weight is zero-extended so the product is a plain signed multiply.
    assign a_ext_s   = {{(B_W + 1){a_i[A_W-1]}}, a_i};
    assign b_ext_s   = {{(A_W + 1){1'b0}}, b_i};
    assign prod_s    = a_ext_s * b_ext_s;
    assign p_ext_s   = {{(CALC_W - P_W){p_q[NUM_STAGE-1][P_W-1]}}, p_q[NUM_STAGE-1]};
    assign acc_ext_s = {{(CALC_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign sum_s     = acc_ext_s + p_ext_s;
    assign rnd_s     = round_shift(acc_ext_s, SHIFT);

    // Multiplier pipeline registers, frozen under global stall.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int s = 0; s < NUM_STAGE; s++) begin
                p_q[s] <= {P_W{1'b0}};
            end
        end else if (adv_i) begin
            p_q[0] <= prod_s;
            for (int s = 1; s < NUM_STAGE; s++) begin
                p_q[s] <= p_q[s-1];
            end
        end
    end

    // Accumulator next state and per-group sticky saturation.
    always_comb begin
        acc_d      = acc_q;
        grp_sat_d  = grp_sat_q;
        emit_sat_d = emit_sat_q;
        sticky_s   = 1'b0;
        if (take_i) begin
            if (add_i) begin
                acc_d    = ACC_W'(sat_to_width(sum_s, ACC_W));
                sticky_s = grp_sat_q | sat_flag(sum_s, ACC_W);
            end else begin
                acc_d    = ACC_W'(p_ext_s);
                sticky_s = 1'b0;
            end
            if (close_i) begin
                grp_sat_d  = 1'b0;
                emit_sat_d = sticky_s;
            end else begin
                grp_sat_d  = sticky_s;
                emit_sat_d = emit_sat_q;
            end
        end else begin
            acc_d      = acc_q;
            grp_sat_d  = grp_sat_q;
            emit_sat_d = emit_sat_q;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q      <= {ACC_W{1'b0}};
            grp_sat_q  <= 1'b0;
            emit_sat_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            grp_sat_q  <= grp_sat_d;
            emit_sat_q <= emit_sat_d;
        end
    end

    // Output register: round, clamp to OUT_W, hold while not loading.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            data_q <= {OUT_W{1'b0}};
            sat_q  <= 1'b0;
        end else if (load_i) begin
            data_q <= OUT_W'(sat_to_width(rnd_s, OUT_W));
            sat_q  <= sat_flag(rnd_s, OUT_W) | emit_sat_q;
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/network_mac_pipe.sv
// LANES-wide signed x unsigned MAC pipe with optional grouped accumulation.
// Owns the handshake, the shared control pipeline and the lane array.
module network_mac_pipe
    import network_mac_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int NUM_STAGE = DEF_NUM_STAGE,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    network_mac_pipe_if.slave bus
);
    logic                   advance_s;
    logic                   accept_s;
    logic                   take_s;
    logic                   add_s;
    logic                   close_s;
    logic                   load_s;
    logic [NUM_STAGE-1:0]   v_q;
    logic [NUM_STAGE-1:0]   ctl_acc_q;
    logic [NUM_STAGE-1:0]   ctl_last_q;
    logic                   grp_open_q;
    logic                   grp_open_d;
    logic                   emit_q;
    logic                   emit_d;
    logic                   out_valid_q;
    logic                   rdy_q;
    logic [LANES*OUT_W-1:0] data_s;
    logic [LANES-1:0]       sat_s;

    assign advance_s    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance_s && rdy_q;
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign take_s       = advance_s && v_q[NUM_STAGE-1];
    assign load_s       = advance_s && emit_q;

    // Accumulate-stage decision: load/add, emit, and group open/close.
    always_comb begin
        add_s      = 1'b0;
        close_s    = 1'b0;
        emit_d     = 1'b0;
        grp_open_d = grp_open_q;
        if (take_s) begin
            add_s      = ctl_acc_q[NUM_STAGE-1] && grp_open_q;
            close_s    = !ctl_acc_q[NUM_STAGE-1] || ctl_last_q[NUM_STAGE-1];
            emit_d     = close_s;
            grp_open_d = ctl_acc_q[NUM_STAGE-1] && !ctl_last_q[NUM_STAGE-1];
        end else begin
            emit_d     = 1'b0;
            grp_open_d = grp_open_q;
        end
    end

    // Control pipeline: valid/acc/last travel alongside the lane products.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v_q         <= {NUM_STAGE{1'b0}};
            ctl_acc_q   <= {NUM_STAGE{1'b0}};
            ctl_last_q  <= {NUM_STAGE{1'b0}};
            grp_open_q  <= 1'b0;
            emit_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (advance_s) begin
                v_q[0]        <= accept_s;
                ctl_acc_q[0]  <= bus.in_acc;
                ctl_last_q[0] <= bus.in_last;
                for (int s = 1; s < NUM_STAGE; s++) begin
                    v_q[s]        <= v_q[s-1];
                    ctl_acc_q[s]  <= ctl_acc_q[s-1];
                    ctl_last_q[s] <= ctl_last_q[s-1];
                end
                grp_open_q  <= grp_open_d;
                emit_q      <= emit_d;
                out_valid_q <= emit_q;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        network_mac_lane #(
            .A_W(A_W), .B_W(B_W), .NUM_STAGE(NUM_STAGE),
            .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
        ) u_lane (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .adv_i    (advance_s),
            .take_i   (take_s),
            .add_i    (add_s),
            .close_i  (close_s),
            .load_i   (load_s),
            .a_i      (bus.in_a[i*A_W +: A_W]),
            .b_i      (bus.in_b),
            .data_o   (data_s[i*OUT_W +: OUT_W]),
            .sat_o    (sat_s[i])
        );
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_s;
    assign bus.out_sat   = sat_s;

endmodule

// File: tb/tb_network_mac_pipe.sv
// Randomized and directed bench for network_mac_pipe against a beat-level
// reference model (grouping, clamping and rounding in plain integer arithmetic).
module tb_network_mac_pipe;
    localparam int LANES = 4, A_W = 16, B_W = 13, NUM_STAGE = 2;
    localparam int ACC_W = 32, SHIFT = 12, OUT_W = 16;

    typedef struct {
        longint           d [LANES];
        logic [LANES-1:0] s;
    } res_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   out_cnt = 0;
    longint last_out0 = 0;

    res_t   exp_q [$];
    bit     grp_open = 1'b0;
    longint acc_m [LANES];
    bit     stk_m [LANES];

    logic [LANES*OUT_W-1:0] held_d;
    logic [LANES-1:0]       held_s;
    bit                     held_v = 1'b0;
    bit                     rand_done = 1'b0;

    network_mac_pipe_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) bus ();

    network_mac_pipe #(
        .LANES(LANES), .A_W(A_W), .B_W(B_W), .NUM_STAGE(NUM_STAGE),
        .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w, output bit hit);
        longint hi = (64'sd1 <<< (w - 1)) - 1;
        longint lo = -(64'sd1 <<< (w - 1));
        hit = (v > hi) || (v < lo);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint floor_div(input longint n, input longint d);
        longint q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: one accepted beat updates the group and may yield a result.
    function automatic void model_beat(input logic [LANES*A_W-1:0] a, input logic [B_W-1:0] b,
                                       input bit acc, input bit last);
        res_t   r;
        bit     h;
        bit     emit = !acc || last;
        longint p;
        longint den = 64'sd1 <<< SHIFT;
        for (int i = 0; i < LANES; i++) begin
            p = longint'($signed(a[i*A_W +: A_W])) * longint'(b);
            if (acc && grp_open) begin
                acc_m[i] = clampw(acc_m[i] + p, ACC_W, h);
                stk_m[i] = stk_m[i] | h;
            end else begin
                acc_m[i] = p;
                stk_m[i] = 1'b0;
            end
            r.d[i] = clampw(floor_div(acc_m[i] + den / 2, den), OUT_W, h);
            r.s[i] = h | stk_m[i];
        end
        grp_open = acc && !last;
        if (emit) exp_q.push_back(r);
    endfunction

    // Negedge monitor: feeds the model, scores results, checks stall behaviour.
    always @(negedge ap_clk) begin
        res_t r;
        if (!ap_rst_n) begin
            exp_q.delete();
            grp_open = 1'b0;
            held_v = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_m[i] = 0;
                stk_m[i] = 1'b0;
            end
        end else begin
            if (held_v) begin
                chk_eq("hold_data", bus.out_data, held_d);
                chk_eq("hold_sat", bus.out_sat, held_s);
            end
            held_v = bus.out_valid && !bus.out_ready;
            if (held_v) begin
                held_d = bus.out_data;
                held_s = bus.out_sat;
                chk_eq("stall_in_ready", bus.in_ready, 0);
            end
            if (bus.in_valid && bus.in_ready)
                model_beat(bus.in_a, bus.in_b, bus.in_acc, bus.in_last);
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                last_out0 = $signed(bus.out_data[OUT_W-1:0]);
                chk_eq("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    for (int i = 0; i < LANES; i++) begin
                        chk_eq($sformatf("lane%0d_data", i),
                               $signed(bus.out_data[i*OUT_W +: OUT_W]), r.d[i]);
                        chk_eq($sformatf("lane%0d_sat", i), bus.out_sat[i], r.s[i]);
                    end
                end
            end
        end
    end

    // Present one beat (called at posedge+1) and hold it until accepted.
    task automatic drive(input logic [LANES*A_W-1:0] a, input logic [B_W-1:0] b,
                         input bit acc, input bit last);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_acc = acc;
        bus.in_last = last;
        for (int n = 0; n < 100; n++) begin
            @(negedge ap_clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("beat_accepted", ok, 1);
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic signed [A_W-1:0] a0,
                          input logic [B_W-1:0] b, input bit acc,
                          input longint exp_d, input bit exp_s);
        int lat = 1;
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        drive({{((LANES - 1) * A_W){1'b0}}, a0}, b, acc, acc);
        for (int n = 0; n < 20; n++) begin
            @(negedge ap_clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge ap_clk);
            #1;
            lat++;
        end
        chk_eq({tag, "_seen"}, seen, 1);
        chk_eq({tag, "_lat"}, lat, NUM_STAGE + 2);
        chk_eq({tag, "_data"}, $signed(bus.out_data[OUT_W-1:0]), exp_d);
        chk_eq({tag, "_sat"}, bus.out_sat[0], exp_s);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge ap_clk);
            #1;
        end
        repeat (6) @(posedge ap_clk);
        #1;
        chk_eq("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [LANES*A_W-1:0] rand_a();
        logic [LANES*A_W-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*A_W +: A_W] = 16'h7FFF;
                1:       v[i*A_W +: A_W] = 16'h8000;
                default: v[i*A_W +: A_W] = A_W'($urandom);
            endcase
        end
        return v;
    endfunction

    initial begin
        int c0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_acc = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge ap_clk);
        chk_eq("rst_out_valid", bus.out_valid, 0);
        chk_eq("rst_out_data", bus.out_data, 0);
        chk_eq("rst_out_sat", bus.out_sat, 0);
        @(posedge ap_clk); #1; ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        chk_eq("rst_in_ready", bus.in_ready, 1);
        @(posedge ap_clk); #1;

        single("pass", 16'sd16384, 13'd4096, 1'b0, 16384, 1'b0);
        single("sat_pos", 16'sh7FFF, 13'd8191, 1'b0, 32767, 1'b1);
        single("sat_neg", 16'sh8000, 13'd8191, 1'b0, -32768, 1'b1);
        single("round_pos", 16'sd1, 13'd2048, 1'b0, 1, 1'b0);
        single("round_neg", -16'sd1, 13'd2048, 1'b0, 0, 1'b0);

        c0 = out_cnt;
        for (int k = 0; k < 4; k++) drive({LANES{16'd4096}}, 13'd4096, 1'b1, k == 3);
        drain();
        chk_eq("acc_out_count", out_cnt - c0, 1);
        chk_eq("acc_value", last_out0, 16384);

        c0 = out_cnt;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    @(posedge ap_clk); #1;
                    bus.out_ready = ~bus.out_ready;
                end
            end
            begin
                for (int k = 0; k < 8; k++) drive(rand_a(), B_W'($urandom), 1'b0, 1'b0);
            end
        join
        drain();
        chk_eq("bp_out_count", out_cnt - c0, 8);

        c0 = out_cnt;
        for (int k = 0; k < 2; k++) drive({LANES{16'd4096}}, 13'd4096, 1'b1, 1'b0);
        repeat (3) @(posedge ap_clk);
        #1; ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk_eq("midrst_out_valid", bus.out_valid, 0);
        chk_eq("midrst_out_data", bus.out_data, 0);
        @(posedge ap_clk); #1; ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        chk_eq("midrst_in_ready", bus.in_ready, 1);
        chk_eq("midrst_no_output", out_cnt - c0, 0);
        @(posedge ap_clk); #1;
        single("rst_acc", 16'sd2, 13'd4096, 1'b1, 2, 1'b0);
        single("rst_pass", 16'sd2, 13'd4096, 1'b0, 2, 1'b0);

        fork
            begin
                for (int n = 0; n < 5000 && !rand_done; n++) begin
                    @(posedge ap_clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge ap_clk); #1;
                    end
                    drive(rand_a(), ($urandom_range(0, 3) == 0) ? 13'd8191 : B_W'($urandom),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0);
                end
                rand_done = 1'b1;
            end
        join
        drive({LANES{16'd0}}, 13'd0, 1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/network_mac_pipe.md
Name: network_mac_pipe

Overview:
- Parametrised successor to the single-cycle signed×unsigned DSP multiplier used by the network datapath.
- Computes LANES parallel signed(A_W) × unsigned(B_W) products against one shared weight, with an optional accumulate mode.
- Each result is rounded, shifted to fixed point, and saturated to OUT_W.
- Multiplier stages are pipelined with a valid/ready handshake; sits between the line-buffer window stage and the activation stage.

Parameters:
- LANES, 4, number of parallel activation lanes sharing one weight
- A_W, 16, signed activation width
- B_W, 13, unsigned weight width (zero-extended before multiply)
- NUM_STAGE, 2, multiplier pipeline registers (≥1)
- ACC_W, 32, accumulator width (≥ A_W+B_W+1)
- SHIFT, 12, fractional bits removed at output (≥1)
- OUT_W, 16, signed output width

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  LANES*A_W  signed activations; lane i at [i*A_W +: A_W]
- in_b  in  B_W  unsigned shared weight
- in_acc  in  1  1 = accumulate this beat into the running group; 0 = pass-through product
- in_last  in  1  closes the accumulation group (ignored when in_acc=0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*OUT_W  signed results, same lane packing
- out_sat  out  LANES  per-lane saturation flag for this result

Behaviour:
- Reset (async assert, sync release): all pipeline valids 0, accumulators 0, group-open flag 0. out_valid=0, out_data=0, out_sat=0; in_ready=1 one cycle after release.
- Stall rule: advance = !out_valid | out_ready. in_ready = advance. Every pipeline register (data and valid) updates only when advance=1. Global stall, no bubbles squeezed.
- Multiply: p = signed(a) × signed({1'b0,b}), P_W = A_W+B_W+1 bits, sign-extended to ACC_W. Carried through NUM_STAGE registers along with in_acc/in_last/valid.
- Accumulate stage, evaluated on a valid beat under advance:
  - in_acc=0: acc = p; emit.
  - in_acc=1, group closed: acc = p; open group.
  - in_acc=1, group open: acc = sat_ACC(acc + p).
  - in_acc=1 and in_last=1: emit and close group.
  - Beats with in_acc=1 and in_last=0 produce no output (valid bubble).
- Accumulator saturation: clamp to ±(2^(ACC_W-1)) range. Sets a per-lane sticky group flag, cleared when the group closes, ORed into out_sat.
- Output stage: r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half-up, arithmetic shift). Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat[i]=1 if lane i clamped here or in the accumulator. Registered; out_valid set on emit.
- Latency: result valid NUM_STAGE+2 cycles after acceptance of the emitting beat, absent backpressure. Throughput 1 beat/cycle.
- out_data/out_sat hold stable while out_valid & !out_ready.
- in_acc=0 beat arriving while a group is open: abandon the group silently and emit the product.
- ap_rst_n asserted mid-group or mid-stall: everything is discarded and there is no partial output.

Decomposition:
- Shared package network_mac_pkg: rounding/saturation functions (sat_to_width, round_shift), lane-slice width constants, derived P_W.
- Sub-module network_mac_lane: one lane's multiply pipeline, accumulator, round/saturate. Driven by the top's common advance/valid/control pipeline.
- Top owns the handshake, the control pipeline, and the LANES generate loop.

Test Plan:
- Pass-through: lane0 a=16384, b=4096, in_acc=0 → after NUM_STAGE+2 cycles out lane0=16384, out_sat=0.
- Positive saturation: a=32767, b=8191 → out=32767, out_sat[lane]=1. Negative saturation: a=-32768, b=8191 → out=-32768, out_sat=1.
- Rounding: a=1, b=2048 → out=1; a=-1, b=2048 → out=0.
- Accumulate: 4 beats a=4096, b=4096, in_acc=1, in_last on beat 4 → exactly one output, value 16384, no output for beats 1–3.
- Backpressure: stream 8 pass-through beats with out_ready toggling 1/0 each cycle → all 8 results in order, no loss or duplication, out_data stable during stall, in_ready=0 while stalled.
- Reset mid-group: 2 accumulate beats, drop ap_rst_n, release, then send pass-through a=2, b=4096 → out=2, no stale sum emitted.
